// File: rtl/dcache_assoc.sv
// N-way set-associative write-back, write-allocate data cache.
// Per-way tag/line storage lives in dcache_assoc_way; the top holds the miss FSM.
`timescale 1ns/1ps

module dcache_assoc_way #(
  parameter int SETS   = 16,
  parameter int IDX_W  = 4,
  parameter int TAG_W  = 23,
  parameter int LINE_W = 256,
  parameter int DATA_W = 32,
  parameter int WSEL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic              fill_en,
  input  logic [IDX_W-1:0]  fill_idx,
  input  logic [TAG_W-1:0]  fill_tag,
  input  logic [LINE_W-1:0] fill_line,
  input  logic              st_en,
  input  logic [WSEL_W-1:0] st_wsel,
  input  logic [DATA_W-1:0] st_data,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line
);
  logic [SETS-1:0]   valid, dirty;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [LINE_W-1:0] line_mem [SETS];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid <= '0;
      dirty <= '0;
    end else if (fill_en) begin
      valid[fill_idx] <= 1'b1;
      dirty[fill_idx] <= 1'b0;
    end else if (st_en) begin
      dirty[rd_idx] <= 1'b1;
    end
  end

  // Tags and lines are qualified by valid, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (fill_en) begin
      tag_mem[fill_idx]  <= fill_tag;
      line_mem[fill_idx] <= fill_line;
    end else if (st_en) begin
      line_mem[rd_idx][st_wsel*DATA_W +: DATA_W] <= st_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_line  = line_mem[rd_idx];
endmodule

module dcache_assoc #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 16,
  parameter int WAYS   = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [DATA_W-1:0] p1_data_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [DATA_W-1:0] p1_data_o,
  output logic              p1_stall_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o
);
  localparam int OFF    = $clog2(LINE_W/8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF - IDX_W;
  localparam int WSEL_W = $clog2(LINE_W/DATA_W);
  localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {IDLE, WB, REFILL} state_t;
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
  } line_addr_t;

  state_t                          state;
  line_addr_t                      req_q;
  logic [WAY_W-1:0]                vic_q, vic, hit_way;
  logic [SETS-1:0][WAY_W-1:0]      vptr;
  logic                            hit, rd, wr, req;
  logic [TAG_W-1:0]                a_tag;
  logic [IDX_W-1:0]                a_idx;
  logic [WSEL_W-1:0]               a_wsel;
  logic [WAYS-1:0]                 way_valid, way_dirty, fill_en, st_en;
  logic [WAYS-1:0][TAG_W-1:0]      way_tag;
  logic [WAYS-1:0][LINE_W-1:0]     way_line;
  logic [LINE_W-1:0]               hit_line;
  logic                            unused_ok;

  assign wr        = p1_MemWrite_i;
  assign rd        = p1_MemRead_i & ~p1_MemWrite_i;
  assign req       = p1_MemRead_i | p1_MemWrite_i;
  assign a_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign a_idx     = p1_addr_i[OFF +: IDX_W];
  assign a_wsel    = p1_addr_i[2 +: WSEL_W];
  assign unused_ok = ^p1_addr_i[1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign fill_en[w] = (state == REFILL) & mem_ack_i & (vic_q == WAY_W'(w));
    assign st_en[w]   = (state == IDLE) & wr & hit & (hit_way == WAY_W'(w));
    dcache_assoc_way #(
      .SETS(SETS), .IDX_W(IDX_W), .TAG_W(TAG_W),
      .LINE_W(LINE_W), .DATA_W(DATA_W), .WSEL_W(WSEL_W)
    ) u_way (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rd_idx   (a_idx),
      .fill_en  (fill_en[w]),
      .fill_idx (req_q.idx),
      .fill_tag (req_q.tag),
      .fill_line(mem_data_i),
      .st_en    (st_en[w]),
      .st_wsel  (a_wsel),
      .st_data  (p1_data_i),
      .rd_valid (way_valid[w]),
      .rd_dirty (way_dirty[w]),
      .rd_tag   (way_tag[w]),
      .rd_line  (way_line[w])
    );
  end

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_valid[w] && way_tag[w] == a_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
  end

  // Lowest-index invalid way wins; otherwise round-robin pointer of the set.
  always_comb begin
    vic = vptr[a_idx];
    for (int w = WAYS-1; w >= 0; w--)
      if (!way_valid[w]) vic = WAY_W'(w);
  end

  assign hit_line   = way_line[hit_way];
  assign p1_data_o  = (state == IDLE && rd && hit) ? hit_line[a_wsel*DATA_W +: DATA_W] : '0;
  assign p1_stall_o = rst_i & ((state != IDLE) | (req & ~hit));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      req_q        <= '0;
      vic_q        <= '0;
      vptr         <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: if (req && !hit) begin
          req_q        <= '{tag: a_tag, idx: a_idx};
          vic_q        <= vic;
          mem_enable_o <= 1'b1;
          mem_data_o   <= way_line[vic];
          if (way_valid[vic] && way_dirty[vic]) begin
            state       <= WB;
            mem_write_o <= 1'b1;
            mem_addr_o  <= {way_tag[vic], a_idx, {OFF{1'b0}}};
          end else begin
            state       <= REFILL;
            mem_write_o <= 1'b0;
            mem_addr_o  <= {a_tag, a_idx, {OFF{1'b0}}};
          end
        end
        WB: if (mem_ack_i) begin
          state       <= REFILL;
          mem_write_o <= 1'b0;
          mem_addr_o  <= {req_q.tag, req_q.idx, {OFF{1'b0}}};
        end
        REFILL: if (mem_ack_i) begin
          state        <= IDLE;
          mem_enable_o <= 1'b0;
          if (WAYS > 1) vptr[req_q.idx] <= vic_q + WAY_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dcache_assoc.sv
// Directed bench for dcache_assoc: memory responder with a transaction
// scoreboard, load-data scoreboard and stall-latency checks.
`timescale 1ns/1ps

module tb_dcache_assoc;
  localparam int ADDR_W = 32, DATA_W = 32, LINE_W = 256, SETS = 16, WAYS = 2;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic [ADDR_W-1:0] p1_addr_i;
  logic [DATA_W-1:0] p1_data_i;
  logic              p1_MemRead_i, p1_MemWrite_i;
  logic [DATA_W-1:0] p1_data_o;
  logic              p1_stall_o;
  logic [LINE_W-1:0] mem_data_i;
  logic              mem_ack_i;
  logic [LINE_W-1:0] mem_data_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_enable_o, mem_write_o;

  dcache_assoc #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W), .SETS(SETS), .WAYS(WAYS)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .p1_addr_i(p1_addr_i), .p1_data_i(p1_data_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] ld_q[$];
  logic [31:0] gold [int unsigned];
  logic [31:0] dram [int unsigned];
  int          total = 0;
  int          bad   = 0;
  int          ack_dly = 3;

  // Backing-store contents before any write-back.
  function automatic logic [31:0] pat(input logic [31:0] a);
    if (a[31:5] == 27'h20) return 32'h11111111 * (32'(a[4:2]) + 32'd1);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] gold_rd(input logic [31:0] a);
    int unsigned k = a >> 2;
    return gold.exists(k) ? gold[k] : pat({a[31:2], 2'b00});
  endfunction

  function automatic logic [31:0] dram_rd(input logic [31:0] a);
    int unsigned k = a >> 2;
    return dram.exists(k) ? dram[k] : pat({a[31:2], 2'b00});
  endfunction

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_txn(input bit wr, input logic [31:0] addr);
    txn_t t;
    t.wr = wr;
    t.addr = addr;
    exp_q.push_back(t);
  endtask

  // Called at the negedge on which ack is raised: score the transaction.
  task automatic serve();
    txn_t              t;
    logic [LINE_W-1:0] line;
    if (exp_q.size() == 0) begin
      chk("unexpected_txn", {mem_write_o, mem_addr_o}, '0);
      return;
    end
    t = exp_q.pop_front();
    chk(t.wr ? "wb_addr" : "refill_addr", {mem_write_o, mem_addr_o}, {t.wr, t.addr});
    if (mem_write_o) begin
      for (int k = 0; k < LINE_W/32; k++) line[k*32 +: 32] = gold_rd(mem_addr_o + 32'(k*4));
      chk("wb_line", mem_data_o, line);
      for (int k = 0; k < LINE_W/32; k++) dram[(mem_addr_o >> 2) + k] = mem_data_o[k*32 +: 32];
    end else begin
      for (int k = 0; k < LINE_W/32; k++) line[k*32 +: 32] = dram_rd(mem_addr_o + 32'(k*4));
      mem_data_i = line;
    end
  endtask

  initial begin : responder
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end else begin
        if (mem_ack_i) begin
          mem_ack_i = 1'b0;
          cnt = 0;
        end
        if (mem_enable_o) begin
          if (cnt >= ack_dly) begin
            mem_ack_i = 1'b1;
            cnt = 0;
            serve();
          end else cnt++;
        end
      end
    end
  end

  // lat = stalled cycles + the completing cycle.
  task automatic access(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d,
                        input int exp_lat, input string tag);
    int n;
    @(negedge clk_i);
    p1_addr_i = a; p1_data_i = d; p1_MemRead_i = rd; p1_MemWrite_i = wr;
    if (rd && !wr) ld_q.push_back(gold_rd(a));
    #1;
    n = 0;
    while (p1_stall_o && n < 200) begin
      @(negedge clk_i);
      #1;
      n++;
    end
    chk({tag, "_lat"}, LINE_W'(n + 1), LINE_W'(exp_lat));
    if (exp_lat == 1) chk({tag, "_no_traffic"}, LINE_W'(mem_enable_o), '0);
    if (rd && !wr) chk({tag, "_data"}, LINE_W'(p1_data_o), LINE_W'(ld_q.pop_front()));
    if (wr) gold[a >> 2] = d;
    @(posedge clk_i);
    #1;
    p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b0;
    p1_addr_i = '0; p1_data_i = '0; p1_MemRead_i = 1'b0; p1_MemWrite_i = 1'b0;
    mem_data_i = '0; mem_ack_i = 1'b0;
    #23;
    chk("rst_stall",  LINE_W'(p1_stall_o),   '0);
    chk("rst_enable", LINE_W'(mem_enable_o), '0);
    chk("rst_write",  LINE_W'(mem_write_o),  '0);
    chk("rst_addr",   LINE_W'(mem_addr_o),   '0);
    chk("rst_mdata",  mem_data_o,            '0);
    chk("rst_pdata",  LINE_W'(p1_data_o),    '0);
    @(negedge clk_i);
    rst_i = 1'b1;

    exp_txn(1'b0, 32'h400);
    access(1, 0, 32'h400, 0, 6, "t1_ld400");
    access(1, 0, 32'h404, 0, 1, "t2_ld404");
    access(0, 1, 32'h408, 32'hDEADBEEF, 1, "t3_st408");
    access(1, 0, 32'h408, 0, 1, "t3_ld408");

    @(negedge clk_i);
    p1_addr_i = 32'h400;
    #1;
    chk("idle_stall", LINE_W'(p1_stall_o), '0);
    chk("idle_data",  LINE_W'(p1_data_o),  '0);

    access(1, 1, 32'h40C, 32'hCAFEF00D, 1, "both_st40c");
    access(1, 0, 32'h40C, 0, 1, "both_ld40c");

    exp_txn(1'b0, 32'h600);
    access(1, 0, 32'h600, 0, 6, "t4_ld600");
    exp_txn(1'b1, 32'h400);
    exp_txn(1'b0, 32'h800);
    access(1, 0, 32'h800, 0, 10, "t4_ld800");
    access(1, 0, 32'h600, 0, 1, "t4_hit600");

    ack_dly = 50;
    @(negedge clk_i);
    p1_addr_i = 32'h400; p1_MemRead_i = 1'b1;
    #1;
    chk("t5_miss_stall", LINE_W'(p1_stall_o), LINE_W'(1));
    @(posedge clk_i);
    #1;
    chk("t5_refill_en", LINE_W'({mem_enable_o, mem_write_o, mem_addr_o}), LINE_W'({1'b1, 1'b0, 32'h400}));
    @(posedge clk_i);
    #2;
    rst_i = 1'b0;
    #1;
    chk("t5_rst_enable", LINE_W'(mem_enable_o), '0);
    chk("t5_rst_stall",  LINE_W'(p1_stall_o),   '0);
    @(negedge clk_i);
    p1_MemRead_i = 1'b0;
    rst_i = 1'b1;
    ack_dly = 3;
    gold.delete();
    foreach (dram[k]) gold[k] = dram[k];

    exp_txn(1'b0, 32'h400);
    access(1, 0, 32'h400, 0, 6, "t5_ld400");
    access(0, 1, 32'h404, 32'h5555AAAA, 1, "t6_st404");
    ack_dly = 0;
    exp_txn(1'b0, 32'h600);
    access(1, 0, 32'h600, 0, 3, "t6_ld600");
    exp_txn(1'b1, 32'h400);
    exp_txn(1'b0, 32'h800);
    access(1, 0, 32'h800, 0, 4, "t6_dirty800");
    exp_txn(1'b0, 32'h400);
    access(1, 0, 32'h404, 0, 3, "t6_ld404");

    repeat (2) @(negedge clk_i);
    chk("txn_q_empty", LINE_W'(exp_q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
